// File: rtl/mat_pkg.sv
`default_nettype none
//============================================================================
// Module      : mat_pkg
// Description : Shared definitions for the matrix stream writer: the FSM
//               state type and the default element width.
// Revision    : 1.0 - initial release
//============================================================================
package mat_pkg;

    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } mat_state_e;

endpackage
`default_nettype wire

// File: rtl/mat_index_counter.sv
`default_nettype none
//============================================================================
// Module      : mat_index_counter
// Description : Row-major row/column index generator with wrap and
//               end-of-row / end-of-matrix detection.
// Ports       : clk, rst     - clock, asynchronous active-high reset
//               clear        - force indices to [0][0] (has priority)
//               advance      - step to the next element in row-major order
//               row, col     - current indices
//               eol          - col is the last column
//               last         - indices point at [SIZE_A-1][SIZE_B-1]
// Revision    : 1.0 - initial release
//============================================================================
module mat_index_counter #(
    parameter int SIZE_A = 8,
    parameter int SIZE_B = 8,
    parameter int ROW_W  = 3,
    parameter int COL_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             eol,
    output logic             last
);

    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(SIZE_A - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(SIZE_B - 1);

    assign eol  = (col == COL_MAX);
    assign last = eol && (row == ROW_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (eol) begin
                col <= '0;
                // Wrapping past the final element returns to [0][0].
                row <= last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mat_stream_writer.sv
`default_nettype none
//============================================================================
// Module      : mat_stream_writer
// Description : Captures a SIZE_A x SIZE_B matrix on start and streams it
//               out element by element in row-major order over a
//               valid/ready interface, then pulses done.
// Ports       : clk, rst     - clock, asynchronous active-high reset
//               start        - capture in_matrix and begin streaming
//               in_matrix    - source matrix
//               out_data     - current element (0 when not valid)
//               out_valid    - out_data is valid
//               out_ready    - sink accepts the element
//               out_row/col  - indices of out_data
//               out_eol      - element is the last of its row
//               out_last     - element is the final one of the matrix
//               busy         - any state other than idle
//               done         - one-cycle pulse after the final transfer
// Revision    : 1.0 - initial release
//============================================================================
module mat_stream_writer
    import mat_pkg::*;
#(
    parameter int SIZE_A = 8,
    parameter int SIZE_B = 8,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    input  logic signed [DATA_W-1:0]                      in_matrix [SIZE_A][SIZE_B],
    output logic        [DATA_W-1:0]                      out_data,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic        [(SIZE_A>1?$clog2(SIZE_A):1)-1:0] out_row,
    output logic        [(SIZE_B>1?$clog2(SIZE_B):1)-1:0] out_col,
    output logic                                          out_eol,
    output logic                                          out_last,
    output logic                                          busy,
    output logic                                          done
);

    localparam int ROW_W = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
    localparam int COL_W = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;

    mat_state_e state;

    logic signed [DATA_W-1:0] mat_buf [SIZE_A][SIZE_B];

    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             eol;
    logic             last;
    logic             load;
    logic             fire;
    logic             streaming;

    assign streaming = (state == ST_STREAM);
    assign fire      = streaming && out_ready;
    // Loading is blocked while rst is high so a reset never disturbs the
    // buffer contents.
    assign load      = (state == ST_IDLE) && start && !rst;

    mat_index_counter #(
        .SIZE_A (SIZE_A),
        .SIZE_B (SIZE_B),
        .ROW_W  (ROW_W),
        .COL_W  (COL_W)
    ) u_index (
        .clk     (clk),
        .rst     (rst),
        .clear   (load),
        .advance (fire),
        .row     (row),
        .col     (col),
        .eol     (eol),
        .last    (last)
    );

    // Buffer is a plain flop array with no reset so the whole matrix lands
    // in one edge and survives a reset.
    always_ff @(posedge clk) begin
        if (load) begin
            mat_buf <= in_matrix;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (fire && last) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from registered state and indices, so the async
    // reset drives them to zero immediately and they hold while stalled.
    assign out_valid = streaming;
    assign out_data  = streaming ? mat_buf[row][col] : '0;
    assign out_row   = streaming ? row : '0;
    assign out_col   = streaming ? col : '0;
    assign out_eol   = streaming && eol;
    assign out_last  = streaming && last;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mat_stream_writer.sv
`default_nettype none
//============================================================================
// Module      : tb_mat_stream_writer
// Description : Self-checking bench for mat_stream_writer (2x3 and 1x1).
// Revision    : 1.0 - initial release
//============================================================================
module tb_mat_stream_writer;

    localparam int A = 2;
    localparam int B = 3;
    localparam int W = 32;
    localparam int N = A * B;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start;
    logic          out_ready;
    logic signed [W-1:0] mat [A][B];
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic [0:0]    out_row;
    logic [1:0]    out_col;
    logic          out_eol, out_last, busy, done;

    logic          s_start, s_ready;
    logic signed [W-1:0] s_mat [1][1];
    logic [W-1:0]  s_data;
    logic          s_valid;
    logic [0:0]    s_row, s_col;
    logic          s_eol, s_last, s_busy, s_done;

    mat_stream_writer #(.SIZE_A(A), .SIZE_B(B), .DATA_W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_matrix(mat),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_col(out_col), .out_eol(out_eol),
        .out_last(out_last), .busy(busy), .done(done)
    );

    mat_stream_writer #(.SIZE_A(1), .SIZE_B(1), .DATA_W(W)) dut1 (
        .clk(clk), .rst(rst), .start(s_start), .in_matrix(s_mat),
        .out_data(s_data), .out_valid(s_valid), .out_ready(s_ready),
        .out_row(s_row), .out_col(s_col), .out_eol(s_eol),
        .out_last(s_last), .busy(s_busy), .done(s_done)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Transaction-level model: an accepted start enqueues the whole matrix
    // in row-major order, each accepted transfer pops one element, and done
    // is owed for the cycle after the queue empties.
    typedef struct {
        logic [W-1:0] d;
        int           r;
        int           c;
    } elem_t;

    elem_t m_q[$];
    bit    m_done_pend = 1'b0;

    // Observed transfers, for literal checks by the directed scenarios.
    logic [W-1:0] got[$];
    bit           got_eol[$];
    bit           got_last[$];
    int           xfer_cyc[$];
    int           done_cyc[$];

    always @(negedge clk) begin
        bit           e_valid;
        logic [W-1:0] e_data;
        int           e_row, e_col;
        e_valid = (m_q.size() > 0);
        e_data  = e_valid ? m_q[0].d : '0;
        e_row   = e_valid ? m_q[0].r : 0;
        e_col   = e_valid ? m_q[0].c : 0;
        if (rst) begin
            e_valid = 1'b0; e_data = '0; e_row = 0; e_col = 0;
        end
        chk("valid", out_valid, e_valid);
        chk("data",  out_data,  e_data);
        chk("row",   out_row,   e_row);
        chk("col",   out_col,   e_col);
        chk("eol",   out_eol,   e_valid && (e_col == B - 1));
        chk("last",  out_last,  e_valid && !rst && (m_q.size() == 1));
        chk("busy",  busy,      !rst && (e_valid || m_done_pend));
        chk("done",  done,      !rst && m_done_pend);

        if (out_valid && out_ready) begin
            got.push_back(out_data);
            got_eol.push_back(out_eol);
            got_last.push_back(out_last);
            xfer_cyc.push_back(cyc);
        end
        if (done) done_cyc.push_back(cyc);

        // Advance the model with the inputs the next rising edge will see.
        if (rst) begin
            m_q.delete();
            m_done_pend = 1'b0;
        end else if (m_done_pend) begin
            m_done_pend = 1'b0;
        end else if (m_q.size() > 0) begin
            if (out_ready) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_done_pend = 1'b1;
            end
        end else if (start) begin
            for (int r = 0; r < A; r++)
                for (int c = 0; c < B; c++)
                    m_q.push_back('{d: mat[r][c], r: r, c: c});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_rec();
        got.delete(); got_eol.delete(); got_last.delete();
        xfer_cyc.delete(); done_cyc.delete();
    endtask

    task automatic load_seq();
        for (int r = 0; r < A; r++)
            for (int c = 0; c < B; c++)
                mat[r][c] = r * B + c + 1;
    endtask

    // Checks that the recorded stream is exactly 1..6 with the right flags.
    task automatic chk_seq(input string nm);
        chk({nm, "_count"}, got.size(), N);
        for (int i = 0; i < N && i < got.size(); i++) begin
            chk({nm, "_val"},  got[i], i + 1);
            chk({nm, "_eol"},  got_eol[i], (i == 2) || (i == 5));
            chk({nm, "_last"}, got_last[i], (i == 5));
        end
    endtask

    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int sc;

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        s_start = 1'b0; s_ready = 1'b1; s_mat[0][0] = 32'h8000_0000;
        load_seq();

        // Reset values, asserted before any clock edge.
        #2;
        chk("rst_valid", out_valid, 0); chk("rst_data", out_data, 0);
        chk("rst_row", out_row, 0);     chk("rst_col", out_col, 0);
        chk("rst_eol", out_eol, 0);     chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
        chk("rst1_valid", s_valid, 0);  chk("rst1_done", s_done, 0);
        tick(3);
        rst = 1'b0;
        tick(1);

        // 1x1 matrix: single element carrying both eol and last.
        s_start = 1'b1;
        tick(1);
        s_start = 1'b0;
        @(negedge clk);
        chk("one_valid", s_valid, 1); chk("one_data", s_data, 32'h8000_0000);
        chk("one_eol", s_eol, 1);     chk("one_last", s_last, 1);
        chk("one_row", s_row, 0);     chk("one_col", s_col, 0);
        @(negedge clk);
        chk("one_valid_off", s_valid, 0); chk("one_done", s_done, 1);
        chk("one_data_off", s_data, 0);
        @(negedge clk);
        chk("one_done_off", s_done, 0);   chk("one_busy_off", s_busy, 0);
        tick(2);

        // Full-rate stream.
        clear_rec();
        start = 1'b1; sc = cyc;
        tick(1);
        start = 1'b0;
        tick(12);
        chk_seq("s1");
        chk("s1_first_lat", (xfer_cyc.size() > 0) ? xfer_cyc[0] - sc : -1, 1);
        chk("s1_no_bubble", (xfer_cyc.size() == N) ? xfer_cyc[N-1] - xfer_cyc[0] : -1, N - 1);
        chk("s1_done_n", done_cyc.size(), 1);
        chk("s1_done_lat", (done_cyc.size() > 0) ? done_cyc[0] - sc : -1, 7);

        // Backpressure pattern 1,0,0,1,...
        clear_rec();
        start = 1'b1;
        for (int k = 0; k < 40; k++) begin
            out_ready = pat[k % 4];
            if (k == 1) start = 1'b0;
            tick(1);
        end
        out_ready = 1'b1;
        tick(2);
        chk_seq("s2");
        chk("s2_done_n", done_cyc.size(), 1);

        // Matrix changed and start re-pulsed mid-stream: both ignored.
        clear_rec();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
        for (int r = 0; r < A; r++)
            for (int c = 0; c < B; c++)
                mat[r][c] = -1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(10);
        chk_seq("s3");
        chk("s3_done_n", done_cyc.size(), 1);
        load_seq();
        tick(2);

        // Reset after the third transfer: immediate, no done pulse.
        clear_rec();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(3);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_valid", out_valid, 0); chk("ar_data", out_data, 0);
        chk("ar_row", out_row, 0);     chk("ar_col", out_col, 0);
        chk("ar_eol", out_eol, 0);     chk("ar_last", out_last, 0);
        chk("ar_busy", busy, 0);       chk("ar_done", done, 0);
        tick(2);
        rst = 1'b0;
        tick(8);
        chk("ar_count", got.size(), 3);
        for (int i = 0; i < 3 && i < got.size(); i++) chk("ar_val", got[i], i + 1);
        chk("ar_no_done", done_cyc.size(), 0);
        clear_rec();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(12);
        chk_seq("ar_restart");
        chk("ar_restart_done", done_cyc.size(), 1);

        // Start held high: second stream accepted in the first idle cycle.
        clear_rec();
        start = 1'b1; sc = cyc;
        tick(16);
        start = 1'b0;
        tick(6);
        chk("hold_count", got.size(), 2 * N);
        for (int i = 0; i < 2 * N && i < got.size(); i++)
            chk("hold_val", got[i], (i % N) + 1);
        chk("hold_done_n", done_cyc.size(), 2);
        chk("hold_done0", (done_cyc.size() > 0) ? done_cyc[0] - sc : -1, 7);
        chk("hold_gap", (done_cyc.size() > 1) ? done_cyc[1] - done_cyc[0] : -1, 8);
        chk("hold_restart", (xfer_cyc.size() > N && done_cyc.size() > 0)
                            ? xfer_cyc[N] - done_cyc[0] : -1, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mat_stream_writer.md
MAT_STREAM_WRITER -- requirements
Module: mat_stream_writer

Interface
REQ-001 SHALL have parameter SIZE_A, default 8: number of matrix rows.
REQ-002 SHALL have parameter SIZE_B, default 8: number of matrix columns.
REQ-003 SHALL have parameter DATA_W, default 32: element width, signed (integer-compatible).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit: request to capture in_matrix and stream it out.
REQ-007 SHALL have port in_matrix, input, unpacked [SIZE_A][SIZE_B] of DATA_W signed: source matrix.
REQ-008 SHALL have port out_data, output, DATA_W: current element.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the sink accepts the element.
REQ-011 SHALL have port out_row, output, $clog2(SIZE_A) bits (min 1): row index of out_data.
REQ-012 SHALL have port out_col, output, $clog2(SIZE_B) bits (min 1): column index of out_data.
REQ-013 SHALL have port out_eol, output, 1 bit: out_data is the last column of its row.
REQ-014 SHALL have port out_last, output, 1 bit: out_data is element [SIZE_A-1][SIZE_B-1].
REQ-015 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-016 SHALL have port done, output, 1 bit: single-cycle pulse after the final transfer.

Function
REQ-017 SHALL implement FSM states IDLE, STREAM and DONE.
REQ-018 SHALL, in IDLE with start=1, copy all of in_matrix into an internal buffer on that edge, clear row/col to 0 and enter STREAM.
REQ-019 SHALL assert out_valid with element [0][0] in the first cycle after start is sampled (latency 1).
REQ-020 SHALL stream elements in row-major order: col increments; at col=SIZE_B-1, col wraps to 0 and row increments.
REQ-021 SHALL count a transfer only in a cycle with out_valid=1 and out_ready=1.
REQ-022 SHALL hold out_data, out_row, out_col, out_eol and out_last stable while out_valid=1 and out_ready=0.
REQ-023 SHALL keep out_valid high throughout STREAM, with no bubbles between back-to-back transfers.
REQ-024 SHALL drive out_eol=1 iff col=SIZE_B-1, and out_last=1 iff row=SIZE_A-1 and col=SIZE_B-1, qualified by out_valid.
REQ-025 SHALL, on the transfer with out_last=1, deassert out_valid on the next cycle and enter DONE.
REQ-026 SHALL assert done=1 for exactly the one cycle spent in DONE, then return to IDLE.
REQ-027 SHALL ignore start outside IDLE; the buffer SHALL NOT change during STREAM or DONE.
REQ-028 SHALL accept a start asserted in the cycle after DONE, in IDLE, with no dead cycle.
REQ-029 SHALL stream exactly one element with out_eol=out_last=1 when SIZE_A=SIZE_B=1.
REQ-030 SHALL drive out_data=0 whenever out_valid=0.

Reset
REQ-031 SHALL, on rst=1 at any time including mid-stream, immediately enter IDLE and abort the transfer without a done pulse.
REQ-032 SHALL hold these reset values: out_valid=0, out_data=0, out_row=0, out_col=0, out_eol=0, out_last=0, busy=0, done=0.
REQ-033 SHALL NOT clear the buffer contents on reset.

Structure
REQ-034 SHALL take the state enum type and the default DATA_W constant from shared package mat_pkg.
REQ-035 SHALL implement row/col index generation with wrap and last detection in sub-module mat_index_counter, instantiated once.
REQ-036 SHALL store the buffer in flops, not inferred RAM, so it loads in one cycle.

Verification
REQ-037 SHALL cover this scenario on a 2x3 matrix {{1,2,3},{4,5,6}} with out_ready=1: start -> 6 transfers of 1..6 on consecutive cycles, out_eol on 3 and 6, out_last on 6, done one cycle later.
REQ-038 SHALL cover this scenario with out_ready toggling 1,0,0,1,...: each element is held unchanged while stalled, the sequence is still 1..6, and no element is duplicated or dropped.
REQ-039 SHALL cover this scenario: in_matrix changed to all -1 and start pulsed again during STREAM -> output is still 1..6 and a single done pulse occurs.
REQ-040 SHALL cover this scenario: rst asserted after the 3rd transfer -> outputs reach reset values without waiting for clk, no done pulse, and a fresh start restarts at [0][0].
REQ-041 SHALL cover this scenario: SIZE_A=SIZE_B=1, element 32'h8000_0000 -> one transfer with out_eol=out_last=1 and out_data=32'h8000_0000.
REQ-042 SHALL cover this scenario: start held high continuously -> a second stream begins in the first IDLE cycle after done.
